// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: deserializes 11-bit device frames and assembles 3-byte movement packets.
// Optional odd-parity checking is compiled in when PS2_PARITY_CHK_EN is defined.
module ps2_mouse_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_err
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic [1:0]             idx;
  logic [2:0]             btn_r;
  logic [3:0]             hi_r;
  logic [7:0]             b1_r;
  logic [WW-1:0]          wdog;
  logic                   timeout, accept, reject, par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  // Watchdog only matters while something is partially received.
  assign timeout = (wdog == WD_MAX) && ((state != IDLE) || (idx != 2'd0));

`ifdef PS2_PARITY_CHK_EN
  logic par_bit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          par_bit <= 1'b0;
    else if (fall && state == PARITY) par_bit <= bit_in;
  end
  assign par_ok = ^{shift, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!bit_in) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (bit_in && par_ok) accept = 1'b1;
          else                  reject = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      idx       <= '0;
      btn_r     <= '0;
      hi_r      <= '0;
      b1_r      <= '0;
      wdog      <= '0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      btn       <= '0;
      dx        <= '0;
      dy        <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;

      if (fall)                wdog <= '0;
      else if (wdog != WD_MAX) wdog <= wdog + 1'b1;

      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shift   <= {bit_in, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Status bit 3 is never checked, so only the used status bits are kept.
      if (accept) begin
        case (idx)
          2'd0: begin
            btn_r <= shift[2:0];
            hi_r  <= shift[7:4];
            idx   <= 2'd1;
          end
          2'd1: begin
            b1_r <= shift;
            idx  <= 2'd2;
          end
          2'd2: begin
            btn       <= btn_r;
            dx        <= {hi_r[0], b1_r};
            dy        <= {hi_r[1], shift};
            x_ovf     <= hi_r[2];
            y_ovf     <= hi_r[3];
            pkt_valid <= 1'b1;
            idx       <= 2'd0;
          end
          default: idx <= 2'd0;
        endcase
      end

      if (reject) begin
        frame_err <= 1'b1;
        idx       <= 2'd0;
      end

      if (timeout) idx <= 2'd0;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Testbench for ps2_mouse_rx: table of packets plus hand-written error, timeout and reset sequences.
// Expected packets go into a queue and are checked when pkt_valid pulses.
module tb_ps2_mouse_rx;

  localparam int TMO  = 200;
  localparam int HALF = 100;   // ps2_clk half period in ns (clk period 10 ns)
  localparam int GAP  = 300;

  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       xo;
    logic       yo;
  } exp_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       pkt_valid, frame_err, x_ovf, y_ovf;
  logic [2:0] btn;
  logic [8:0] dx, dy;

  int   tests = 0, fails = 0, err_seen = 0, err_exp = 0;
  exp_t q[$];
  vec_t vecs[6];

  ps2_mouse_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy),
    .x_ovf(x_ovf), .y_ovf(y_ovf), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      exp_t got, e;
      got = '{btn, dx, dy, x_ovf, y_ovf};
      if (pkt_valid && frame_err) begin
        tests++; fails++;
        $display("FAIL excl: pkt_valid and frame_err both high at %0t", $time);
      end
      if (frame_err) err_seen++;
      if (pkt_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pkt: got %h, required no packet", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL pkt: got btn=%b dx=%h dy=%h xo=%b yo=%b, required btn=%b dx=%h dy=%h xo=%b yo=%b",
                     got.btn, got.dx, got.dy, got.xo, got.yo, e.btn, e.dx, e.dy, e.xo, e.yo);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #(HALF);
    ps2_clk = 1'b0;
    #(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    logic p;
    p = ~^b ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_data = 1'b1;
    #(GAP);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 0, 1);
    send_frame(b1, 0, 1);
    send_frame(b2, 0, 1);
  endtask

  task automatic idle_wait();
    repeat (TMO + 100) @(posedge clk);
  endtask

  task automatic check_point(input string name);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: %0d packets outstanding, required 0", name, q.size());
      q.delete();
    end
    tests++;
    if (err_seen != err_exp) begin
      fails++;
      $display("FAIL %s_errs: frame_err count %0d, required %0d", name, err_seen, err_exp);
      err_exp = err_seen;
    end
  endtask

  task automatic check_reset(input string name);
    exp_t got;
    @(negedge clk);
    got = '{btn, dx, dy, x_ovf, y_ovf};
    tests++;
    if (got !== '0 || pkt_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got outs=%h pv=%b fe=%b, required all 0", name, got, pkt_valid, frame_err);
    end
  endtask

  initial begin
    vecs[0] = '{8'h21, 8'h55, 8'hAA, '{3'b001, 9'h055, 9'h1AA, 1'b0, 1'b0}};
    vecs[1] = '{8'h08, 8'h00, 8'h00, '{3'b000, 9'h000, 9'h000, 1'b0, 1'b0}};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, '{3'b111, 9'h1FF, 9'h1FF, 1'b1, 1'b1}};
    vecs[3] = '{8'h3C, 8'h80, 8'h7F, '{3'b100, 9'h180, 9'h17F, 1'b0, 1'b0}};
    vecs[4] = '{8'hC9, 8'h01, 8'h02, '{3'b001, 9'h001, 9'h002, 1'b1, 1'b1}};
    vecs[5] = '{8'h12, 8'hF0, 8'h10, '{3'b010, 9'h1F0, 9'h010, 1'b0, 1'b0}};

    repeat (5) @(posedge clk);
    check_reset("reset_state");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      q.push_back(vecs[i].e);
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check_point($sformatf("vec%0d", i));
    end

    // Bad parity on a lone 0x55 ahead of a good packet
    send_frame(8'h55, 1, 1);
`ifdef PS2_PARITY_CHK_EN
    err_exp++;
    q.push_back(vecs[0].e);
`else
    q.push_back('{3'b101, 9'h121, 9'h055, 1'b1, 1'b0});
`endif
    send_pkt(8'h21, 8'h55, 8'hAA);
    idle_wait();
    check_point("bad_parity");

    // Stop bit 0 on the second byte
    send_frame(8'h21, 0, 1);
    send_frame(8'h55, 0, 0);
    err_exp++;
    q.push_back(vecs[3].e);
    send_pkt(vecs[3].b0, vecs[3].b1, vecs[3].b2);
    check_point("bad_stop");

    // Two bytes, long idle, then a full packet
    send_frame(8'hFF, 0, 1);
    send_frame(8'hFF, 0, 1);
    idle_wait();
    q.push_back(vecs[5].e);
    send_pkt(vecs[5].b0, vecs[5].b1, vecs[5].b2);
    check_point("timeout");

    // Reset after the 4th data bit of the first byte
    q.push_back(vecs[2].e);
    send_pkt(vecs[2].b0, vecs[2].b1, vecs[2].b2);
    check_point("pre_reset");
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_reset("mid_frame_reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    q.push_back(vecs[4].e);
    send_pkt(vecs[4].b0, vecs[4].b1, vecs[4].b2);
    check_point("post_reset");

    // Stray falling edge with data high while idle
    ps2_bit(1'b1);
    #(GAP);
    q.push_back(vecs[0].e);
    send_pkt(vecs[0].b0, vecs[0].b1, vecs[0].b2);
    check_point("idle_edge");

    repeat (20) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_rx.md
PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on ps2_clk and ps2_data (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, number of idle clk cycles with no ps2_clk falling edge after which a partial frame or packet is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; one clock only, required ≥ 8× ps2_clk frequency.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 SHALL have port pkt_valid  output  1  one-cycle pulse: btn/dx/dy/x_ovf/y_ovf hold a new packet.
REQ-008 SHALL have port btn  output  3  {middle, right, left} = status byte bits [2:0].
REQ-009 SHALL have port dx  output  9  signed X delta {status[4], byte1}.
REQ-010 SHALL have port dy  output  9  signed Y delta {status[5], byte2}.
REQ-011 SHALL have port x_ovf  output  1  status[6].
REQ-012 SHALL have port y_ovf  output  1  status[7].
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops; a falling edge is synchronized ps2_clk going 1→0 between consecutive clk cycles.
REQ-015 SHALL sample synchronized ps2_data only on detected falling edges.
REQ-016 SHALL run a frame FSM with states IDLE, DATA, PARITY, STOP.
REQ-017 In IDLE, an edge with data 0 (start bit) SHALL go to DATA; an edge with data 1 SHALL be ignored, FSM stays in IDLE.
REQ-018 DATA SHALL shift in 8 bits LSB first, moving to PARITY after the 8th edge.
REQ-019 PARITY SHALL record the parity bit and move to STOP on the next edge.
REQ-020 STOP SHALL return to IDLE on its edge; stop bit 1 means the byte is accepted, stop bit 0 means frame_err pulses, byte is discarded.
REQ-021 SHALL keep a byte index 0..2; an accepted byte is stored as status/byte1/byte2 per index, and the index increments, wrapping 2→0.
REQ-022 On acceptance of byte index 2, SHALL update btn/dx/dy/x_ovf/y_ovf and pulse pkt_valid exactly one cycle; both occur within 2 clk cycles after the stop-bit edge is detected.
REQ-023 Outputs SHALL hold their last values between packets.
REQ-024 Any frame_err SHALL reset the byte index to 0, discarding the partial packet.
REQ-025 SHALL run a watchdog counter cleared on every falling edge; when it reaches TIMEOUT_CYC while FSM ≠ IDLE or byte index ≠ 0, FSM SHALL go IDLE and index to 0, without frame_err.
REQ-026 pkt_valid and frame_err SHALL never assert in the same cycle.
REQ-027 No check of status bit 3 is performed; packet alignment relies on the watchdog and error recovery only.

Reset
REQ-028 rst SHALL asynchronously clear all flops: FSM=IDLE, byte index=0, watchdog=0, synchronizers=1.
REQ-029 Reset values: pkt_valid=0, frame_err=0, btn=0, dx=0, dy=0, x_ovf=0, y_ovf=0.
REQ-030 Reset mid-frame SHALL discard all partial data; reception resumes with the next start bit after rst deasserts.

Configuration
REQ-031 With macro PS2_PARITY_CHK_EN defined, PARITY SHALL check odd parity over the 8 data bits plus the parity bit; on mismatch, frame_err pulses at the stop edge and the byte is discarded per REQ-024.
REQ-032 Without PS2_PARITY_CHK_EN, the parity bit SHALL be sampled and ignored; no logic for the check is generated.

Verification
REQ-033 Frames 0x21, 0x55, 0xAA, each with parity 1 and stop 1 -> one pkt_valid; btn=3'b001, dx=+85 (9'h055), dy=-86 (9'h1AA), x_ovf=0, y_ovf=0.
REQ-034 Byte 0x55 sent with parity 0, macro defined -> frame_err pulse, no pkt_valid; the following three good frames -> one packet. Same stimulus with macro undefined -> no frame_err; the three frames carrying the bad parity bit form a packet.
REQ-035 Frame with stop bit 0 as second byte -> frame_err; the next three good frames -> one correct packet.
REQ-036 Two good bytes, then ps2_clk idle > TIMEOUT_CYC, then three good bytes -> exactly one pkt_valid, with values from the last three bytes.
REQ-037 rst pulse after the 4th data bit of byte 1 -> all outputs at reset values; the next full packet decodes correctly.
REQ-038 Falling edge with ps2_data=1 while IDLE -> no state change; a subsequent valid packet decodes correctly.
